// File: rtl/brightness_pkg.sv
// Shared constants, coefficient-set type and helper functions for the
// brightness/contrast filter.
package brightness_pkg;

   localparam int PIPE_LAT     = 3;
   // Coefficient fields are sized for the widest supported configuration;
   // narrower gains are zero-extended and offsets sign-extended into them.
   localparam int GAIN_MAX_W   = 16;
   localparam int OFFSET_MAX_W = 17;

   typedef struct packed {
      logic [GAIN_MAX_W-1:0]   gain;
      logic [OFFSET_MAX_W-1:0] offset;   // two's complement
      logic                    bypass;
   } coe_set_t;

   function automatic int mid_grey(input int width);
      return 1 << (width - 1);
   endfunction

   function automatic int saturate(input int value, input int width);
      int max_v;
      max_v = (1 << width) - 1;
      if (value < 0)
         return 0;
      else if (value > max_v)
         return max_v;
      return value;
   endfunction

endpackage

// File: rtl/brightness_contrast_if.sv
// Pixel stream and coefficient bus of the brightness/contrast filter.
interface brightness_contrast_if #(
   parameter int PIXEL_WIDTH = 8,
   parameter int COE_WIDTH   = 9
);
   logic [COE_WIDTH-1:0]         gain_i;
   logic signed [PIXEL_WIDTH:0]  offset_i;
   logic                         bypass_i;
   logic                         coe_wr_i;
   logic                         coe_pending_o;
   logic [PIXEL_WIDTH-1:0]       y_i, cb_i, cr_i;
   logic                         de_i, hs_i, vs_i;
   logic [PIXEL_WIDTH-1:0]       y_o, cb_o, cr_o;
   logic                         de_o, hs_o, vs_o;

   modport master (
      output gain_i, offset_i, bypass_i, coe_wr_i,
      output y_i, cb_i, cr_i, de_i, hs_i, vs_i,
      input  coe_pending_o,
      input  y_o, cb_o, cr_o, de_o, hs_o, vs_o
   );

   modport slave (
      input  gain_i, offset_i, bypass_i, coe_wr_i,
      input  y_i, cb_i, cr_i, de_i, hs_i, vs_i,
      output coe_pending_o,
      output y_o, cb_o, cr_o, de_o, hs_o, vs_o
   );
endinterface

// File: rtl/brightness_alu.sv
// Three-stage luma datapath: centre on mid-grey, apply gain, round, add
// offset and saturate. Blanks on de and honours bypass from the snapshot.
module brightness_alu
   import brightness_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8,
   parameter int COE_FRAC    = 7
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PIXEL_WIDTH-1:0] pix,
   input  coe_set_t               coe,
   input  logic                   de_s2,
   output logic [PIXEL_WIDTH-1:0] result
);

   localparam int P_W = PIXEL_WIDTH + GAIN_MAX_W + 2;
   localparam int S_W = P_W + 2;
   localparam logic signed [PIXEL_WIDTH:0] MID   = (PIXEL_WIDTH+1)'(mid_grey(PIXEL_WIDTH));
   localparam logic signed [P_W-1:0]       ROUND = P_W'(1 << (COE_FRAC - 1));

   logic signed [PIXEL_WIDTH:0]     d1;
   logic [PIXEL_WIDTH-1:0]          pix1, pix2;
   coe_set_t                        coe1;
   logic signed [P_W-1:0]           p2;
   logic signed [OFFSET_MAX_W-1:0]  off2;
   logic                            byp2;
   logic signed [P_W-1:0]           r;
   logic signed [S_W-1:0]           s;
   logic [PIXEL_WIDTH-1:0]          sat_y;

   // NOTE: every pipeline register uses <= so all stages sample the values
   // from before the edge; blocking here would collapse stages together.
   always_ff @(posedge clk) begin
      if (rst) begin
         d1     <= '0;
         pix1   <= '0;
         coe1   <= '0;
         p2     <= '0;
         off2   <= '0;
         byp2   <= 1'b0;
         pix2   <= '0;
         result <= '0;
      end else begin
         d1     <= $signed({1'b0, pix}) - MID;
         pix1   <= pix;
         coe1   <= coe;
         p2     <= P_W'(d1) * P_W'($signed({1'b0, coe1.gain}));
         off2   <= $signed(coe1.offset);
         byp2   <= coe1.bypass;
         pix2   <= pix1;
         result <= !de_s2 ? '0 : (byp2 ? pix2 : sat_y);
      end
   end

   // Round half up, then re-centre and add brightness with two guard bits.
   always_comb begin
      r     = (p2 + ROUND) >>> COE_FRAC;
      s     = S_W'(r) + S_W'(MID) + S_W'(off2);
      sat_y = PIXEL_WIDTH'(saturate(int'(s), PIXEL_WIDTH));
   end

endmodule

// File: rtl/brightness_contrast.sv
// YCbCr brightness/contrast filter: frame-synchronous coefficient double
// buffer, vs boundary detector, luma datapath and matched chroma/sync delays.
module brightness_contrast
   import brightness_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8,
   parameter int COE_WIDTH   = 9,
   parameter int COE_FRAC    = 7,
   parameter bit VS_ACTIVE   = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   brightness_contrast_if.slave bus
);

   localparam coe_set_t UNITY_SET = '{gain: GAIN_MAX_W'(1) << COE_FRAC, offset: '0, bypass: 1'b0};

   logic [COE_WIDTH-1:0]        gain_w;
   logic signed [PIXEL_WIDTH:0] offset_w;
   coe_set_t                    wr_set, pending_set, active_set, frame_set;
   logic                        pending_valid, vs_prev, boundary, apply;

   logic [PIXEL_WIDTH-1:0] cb_d [PIPE_LAT-1];
   logic [PIXEL_WIDTH-1:0] cr_d [PIPE_LAT-1];
   logic [2:0]             tm_d [PIPE_LAT-1];   // {de, hs, vs}

   assign gain_w   = bus.gain_i;
   assign offset_w = bus.offset_i;

   // NOTE: each signal written here gets a value on every path, so no latch.
   always_comb begin
      wr_set.gain   = GAIN_MAX_W'(gain_w);
      wr_set.offset = OFFSET_MAX_W'(offset_w);
      wr_set.bypass = bus.bypass_i;
      boundary      = (bus.vs_i == VS_ACTIVE) && (vs_prev != VS_ACTIVE);
      apply         = boundary && pending_valid;
      // The pixel sampled on the boundary cycle already uses the new set.
      frame_set     = apply ? pending_set : active_set;
   end

   // A write coinciding with the boundary lands in pending; the old pending
   // set is what gets promoted.
   always_ff @(posedge clk) begin
      if (rst) begin
         vs_prev       <= ~VS_ACTIVE;
         pending_valid <= 1'b0;
         pending_set   <= '0;
         active_set    <= UNITY_SET;
      end else begin
         vs_prev <= bus.vs_i;
         if (apply)
            active_set <= pending_set;
         if (bus.coe_wr_i) begin
            pending_set   <= wr_set;
            pending_valid <= 1'b1;
         end else if (boundary) begin
            pending_valid <= 1'b0;
         end
      end
   end

   assign bus.coe_pending_o = pending_valid;

   // NOTE: the delay lines are reset element by element so a reset flushes
   // the whole pipeline, not just the output stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PIPE_LAT-1; i++) begin
            cb_d[i] <= '0;
            cr_d[i] <= '0;
            tm_d[i] <= '0;
         end
         bus.cb_o <= '0;
         bus.cr_o <= '0;
         bus.de_o <= 1'b0;
         bus.hs_o <= 1'b0;
         bus.vs_o <= 1'b0;
      end else begin
         cb_d[0] <= bus.cb_i;
         cr_d[0] <= bus.cr_i;
         tm_d[0] <= {bus.de_i, bus.hs_i, bus.vs_i};
         for (int i = 1; i < PIPE_LAT-1; i++) begin
            cb_d[i] <= cb_d[i-1];
            cr_d[i] <= cr_d[i-1];
            tm_d[i] <= tm_d[i-1];
         end
         bus.cb_o <= tm_d[PIPE_LAT-2][2] ? cb_d[PIPE_LAT-2] : '0;
         bus.cr_o <= tm_d[PIPE_LAT-2][2] ? cr_d[PIPE_LAT-2] : '0;
         bus.de_o <= tm_d[PIPE_LAT-2][2];
         bus.hs_o <= tm_d[PIPE_LAT-2][1];
         bus.vs_o <= tm_d[PIPE_LAT-2][0];
      end
   end

   brightness_alu #(
      .PIXEL_WIDTH (PIXEL_WIDTH),
      .COE_FRAC    (COE_FRAC)
   ) u_alu (
      .clk    (clk),
      .rst    (rst),
      .pix    (bus.y_i),
      .coe    (frame_set),
      .de_s2  (tm_d[PIPE_LAT-2][2]),
      .result (bus.y_o)
   );

endmodule

// File: doc/brightness_contrast.md
Name: brightness_contrast

Overview:
- Parametrised successor to the fixed brightness filter, placed in the YCbCr video filter chain.
- Applies gain (contrast about mid-grey) and signed offset (brightness) to Y; Cb/Cr and the syncs pass through with matched delay.
- Coefficients are double-buffered. New values take effect only at a frame boundary, so no frame is ever processed with mixed settings.
- Optional bypass.

Parameters:
- PIXEL_WIDTH, 8, bits per component.
- COE_WIDTH, 9, unsigned gain width.
- COE_FRAC, 7, gain fractional bits (unity = 2^COE_FRAC = 128).
- VS_ACTIVE, 1, active level of vs_i; the frame boundary is the transition into the active level.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- gain_i  in  COE_WIDTH  unsigned fixed-point gain, pending value
- offset_i  in  PIXEL_WIDTH+1  signed brightness offset, pending value
- bypass_i  in  1  pending bypass flag
- coe_wr_i  in  1  one-cycle strobe; captures gain_i/offset_i/bypass_i into pending set
- coe_pending_o  out  1  pending set captured, not yet applied
- y_i/cb_i/cr_i  in  PIXEL_WIDTH each  input pixel
- de_i/hs_i/vs_i  in  1 each  input timing
- y_o/cb_o/cr_o  out  PIXEL_WIDTH each  output pixel
- de_o/hs_o/vs_o  out  1 each  output timing

Behaviour:
- Reset state:
  - All outputs 0.
  - Pending set cleared; coe_pending_o=0.
  - Active set: gain=2^COE_FRAC, offset=0, bypass=0.
  - vs edge detector history = inactive.
- Coefficient capture: coe_wr_i=1 loads the pending set and sets coe_pending_o=1. A later write before the boundary overwrites the pending set (last write wins).
- Frame boundary:
  - Defined as the cycle where vs_i is at VS_ACTIVE and the registered previous vs_i was not.
  - If coe_pending_o=1 on that cycle: active set <= pending set and coe_pending_o clears.
  - The new active set is applied starting with the pixel sampled in that same cycle.
- Simultaneous coe_wr_i and boundary:
  - Active set takes the OLD pending set.
  - New values go into pending; coe_pending_o stays 1.
  - If nothing was pending, active is unchanged and the new values remain pending.
- Pipeline, fixed latency 3 clk for all outputs, no stalls:
  - S1: d = signed(y_i) - 2^(PIXEL_WIDTH-1), width PIXEL_WIDTH+1. Register cb/cr/de/hs/vs and a snapshot of the active set.
  - S2: p = d * gain, signed, width PIXEL_WIDTH+COE_WIDTH+2.
  - S3: r = (p + 2^(COE_FRAC-1)) >>> COE_FRAC (arithmetic shift). Then s = r + 2^(PIXEL_WIDTH-1) + offset, computed with guard bits. Saturate s to [0, 2^PIXEL_WIDTH-1].
- Bypass (active set): y_o = y_i delayed 3 clk; arithmetic result ignored.
- Blanking: when de_o=0, y_o/cb_o/cr_o are forced to 0. hs_o/vs_o are the plain 3-cycle delays.
- Gain 0: y_o = sat(2^(PIXEL_WIDTH-1) + offset) for every active pixel.
- Reset mid-frame:
  - Pipeline flushes; outputs are 0 on the cycle after rst.
  - Active set returns to unity; pending is lost.
  - A vs_i already active when rst deasserts does not count as a boundary until vs goes inactive and returns.

Decomposition:
- Package brightness_pkg: PIPE_LAT=3 constant, mid-grey constant function, saturate function, coefficient-set struct (gain, offset, bypass).
- Sub-module brightness_alu: the S1–S3 Y datapath, fed with the snapshot coefficient set.
- The top holds the coefficient double-buffer, boundary detector and sync/chroma delay lines.

Test Plan:
- Unity after reset: y_i=200, de_i=1 -> y_o=200 after exactly 3 clk. cb_i=90/cr_i=160 appear unchanged 3 clk later.
- Gain 129, offset 0, applied at boundary: y=200 -> 201; y=128 -> 128; y=0 -> 0 (-128*129=-16512, +64 >>>7 = -129, +128 = -1 -> sat 0).
- Saturation: gain 256, y=200 -> 255. Offset -200, gain 128, y=100 -> 0.
- Frame sync: coe_wr_i mid-frame with gain 256 -> coe_pending_o=1 and output unchanged until the vs rising edge. The pixel sampled on that edge cycle uses the new gain; coe_pending_o=0 next cycle.
- Simultaneous write/edge: pending gain 256, write gain 64 on the edge cycle -> frame uses 256, coe_pending_o stays 1, next frame uses 64.
- Reset and blanking: rst pulse mid-frame -> all outputs 0 next cycle and gain back to unity. With de_i=0, y_i=77 -> y_o=0 while hs/vs are delayed 3 clk.
